// File: rtl/uart_cmd_frame_engine_pkg.sv
// Shared constants for the UART command frame engine: FSM state codes,
// ASCII framing bytes and error codes.
package uart_cmd_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_RX_DIGITS = 3'd1;
    localparam logic [2:0] ST_COMMIT    = 3'd2;
    localparam logic [2:0] ST_LOAD_RSP  = 3'd3;
    localparam logic [2:0] ST_TX_BYTE   = 3'd4;
    localparam logic [2:0] ST_TX_WAIT   = 3'd5;

    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_ACK  = 8'h41;
    localparam logic [7:0] ASCII_ERR  = 8'h45;
    localparam logic [7:0] DIGIT_BASE = 8'h30;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_DIGIT   = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    function automatic logic is_ascii_digit(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h39);
    endfunction

endpackage

// File: rtl/uart_cmd_frame_engine_tx_seq.sv
// Transmit sequencer: holds a byte buffer (head in the top byte) and hands
// bytes one at a time to the UART transmitter using the tx_busy handshake.
module uart_tx_seq
    import uart_cmd_pkg::*;
#(
    parameter int unsigned N_BYTES = 16,
    parameter int unsigned LEN_W   = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [8*N_BYTES-1:0]   load_vec,
    input  logic [LEN_W-1:0]       load_len,
    input  logic                   tx_busy,
    output logic [7:0]             tx_byte,
    output logic                   tx_start,
    output logic                   done
);

    localparam int unsigned BUF_W = 8 * N_BYTES;

    logic [2:0]       phase_q;
    logic [BUF_W-1:0] buf_q;
    logic [LEN_W-1:0] cnt_q;
    logic             first_q;

    assign tx_byte  = buf_q[BUF_W-1 -: 8];
    assign tx_start = (phase_q == ST_TX_BYTE) && !tx_busy;
    assign done     = (phase_q == ST_TX_WAIT) && !first_q && !tx_busy
                      && (cnt_q == LEN_W'(1));

    // tx_busy only rises the cycle after tx_start, so the first TX_WAIT
    // cycle is skipped before trusting tx_busy==0 as "byte finished".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= ST_IDLE;
            buf_q   <= '0;
            cnt_q   <= '0;
            first_q <= 1'b0;
        end else if (load) begin
            buf_q   <= load_vec;
            cnt_q   <= load_len;
            phase_q <= ST_TX_BYTE;
            first_q <= 1'b0;
        end else begin
            case (phase_q)
                ST_TX_BYTE: begin
                    if (!tx_busy) begin
                        phase_q <= ST_TX_WAIT;
                        first_q <= 1'b1;
                    end
                end
                ST_TX_WAIT: begin
                    if (first_q) begin
                        first_q <= 1'b0;
                    end else if (!tx_busy) begin
                        buf_q   <= buf_q << 8;
                        cnt_q   <= cnt_q - LEN_W'(1);
                        phase_q <= (cnt_q == LEN_W'(1)) ? ST_IDLE : ST_TX_BYTE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/uart_cmd_frame_engine.sv
// Parses SET/REQ command frames from a UART byte stream, commits BCD set
// data, and replies with ACK/ERR or an ASCII snapshot of req_bcd.
module uart_cmd_frame_engine
    import uart_cmd_pkg::*;
#(
    parameter int unsigned N_DIGITS       = 14,
    parameter logic [7:0]  SET_CHAR       = 8'h4B,
    parameter logic [7:0]  REQ_CHAR       = 8'h52,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter bit          ACK_EN         = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_byte,
    output logic [7:0]            tx_byte,
    output logic                  tx_start,
    input  logic                  tx_busy,
    input  logic [4*N_DIGITS-1:0] req_bcd,
    output logic [4*N_DIGITS-1:0] set_bcd,
    output logic                  set_valid,
    output logic                  busy,
    output logic                  err_pulse,
    output logic [1:0]            err_code
);

    localparam int unsigned BCD_W   = 4 * N_DIGITS;
    localparam int unsigned N_BYTES = N_DIGITS + 2;
    localparam int unsigned BUF_W   = 8 * N_BYTES;
    localparam int unsigned LEN_W   = $clog2(N_BYTES + 1);
    localparam int unsigned CNT_W   = $clog2(N_DIGITS + 1);
    localparam int unsigned TIM_W   = $clog2(TIMEOUT_CYCLES + 1);

    logic [2:0]       state_q;
    logic [CNT_W-1:0] dcnt_q;
    logic [TIM_W-1:0] timer_q;
    logic [BCD_W-1:0] shift_q;
    logic [BCD_W-1:0] shift_next;

    logic             in_rx, rx_digit, bad_byte, timeout_hit;
    logic             seq_load, seq_done;
    logic [BUF_W-1:0] load_vec;
    logic [LEN_W-1:0] load_len;

    assign busy        = (state_q != ST_IDLE);
    assign in_rx       = (state_q == ST_RX_DIGITS);
    assign rx_digit    = is_ascii_digit(rx_byte);
    assign bad_byte    = in_rx && rx_valid && !rx_digit;
    assign timeout_hit = in_rx && !rx_valid && (timer_q == TIM_W'(TIMEOUT_CYCLES - 1));
    assign shift_next  = (shift_q << 4) | BCD_W'(rx_byte[3:0]);

    always_comb begin
        seq_load = 1'b0;
        load_vec = '0;
        load_len = '0;
        if (bad_byte || timeout_hit) begin
            seq_load                 = 1'b1;
            load_vec[BUF_W-1 -: 24]  = {ASCII_ERR, ASCII_CR, ASCII_LF};
            load_len                 = LEN_W'(3);
        end else if ((state_q == ST_COMMIT) && ACK_EN) begin
            seq_load                 = 1'b1;
            load_vec[BUF_W-1 -: 24]  = {ASCII_ACK, ASCII_CR, ASCII_LF};
            load_len                 = LEN_W'(3);
        end else if (state_q == ST_LOAD_RSP) begin
            // Loading the buffer here is the snapshot latch of req_bcd.
            seq_load = 1'b1;
            for (int unsigned i = 0; i < N_DIGITS; i++) begin
                load_vec[BUF_W-1-8*i -: 8] = DIGIT_BASE | {4'h0, req_bcd[BCD_W-1-4*i -: 4]};
            end
            load_vec[15:0] = {ASCII_CR, ASCII_LF};
            load_len       = LEN_W'(N_BYTES);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            dcnt_q    <= '0;
            timer_q   <= '0;
            shift_q   <= '0;
            set_bcd   <= '0;
            set_valid <= 1'b0;
            err_pulse <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            set_valid <= 1'b0;
            err_pulse <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (rx_valid && (rx_byte == SET_CHAR)) begin
                        state_q <= ST_RX_DIGITS;
                        dcnt_q  <= '0;
                        timer_q <= '0;
                    end else if (rx_valid && (rx_byte == REQ_CHAR)) begin
                        state_q <= ST_LOAD_RSP;
                    end
                end
                ST_RX_DIGITS: begin
                    if (rx_valid) begin
                        timer_q <= '0;
                        if (rx_digit) begin
                            shift_q <= shift_next;
                            dcnt_q  <= dcnt_q + CNT_W'(1);
                            if (dcnt_q == CNT_W'(N_DIGITS - 1)) state_q <= ST_COMMIT;
                        end else begin
                            err_code  <= ERR_DIGIT;
                            err_pulse <= 1'b1;
                            state_q   <= ST_TX_BYTE;
                        end
                    end else if (timeout_hit) begin
                        err_code  <= ERR_TIMEOUT;
                        err_pulse <= 1'b1;
                        state_q   <= ST_TX_BYTE;
                    end else begin
                        timer_q <= timer_q + TIM_W'(1);
                    end
                end
                ST_COMMIT: begin
                    set_bcd   <= shift_q;
                    set_valid <= 1'b1;
                    state_q   <= ACK_EN ? ST_TX_BYTE : ST_IDLE;
                end
                ST_LOAD_RSP: state_q <= ST_TX_BYTE;
                // Byte/wait phases live in the sequencer; wait for its last byte.
                ST_TX_BYTE: if (seq_done) state_q <= ST_IDLE;
                default:    state_q <= ST_IDLE;
            endcase
        end
    end

    uart_tx_seq #(
        .N_BYTES (N_BYTES),
        .LEN_W   (LEN_W)
    ) u_tx_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (seq_load),
        .load_vec (load_vec),
        .load_len (load_len),
        .tx_busy  (tx_busy),
        .tx_byte  (tx_byte),
        .tx_start (tx_start),
        .done     (seq_done)
    );

endmodule

// File: tb/tb_uart_cmd_frame_engine.sv
// Directed self-checking bench for uart_cmd_frame_engine with a simple
// UART transmitter model driving tx_busy.
module tb_uart_cmd_frame_engine;

    logic        clk, rst_n, rx_valid, tx_start, tx_busy;
    logic [7:0]  rx_byte, tx_byte;
    logic [55:0] req_bcd, set_bcd;
    logic        set_valid, busy, err_pulse;
    logic [1:0]  err_code;

    int checks, errors;
    int tx_count, sv_count, ep_count, busy_len;
    logic [7:0] tx_log [64];
    logic [7:0] cur_byte;

    uart_cmd_frame_engine #(
        .N_DIGITS       (14),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .tx_byte   (tx_byte),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .req_bcd   (req_bcd),
        .set_bcd   (set_bcd),
        .set_valid (set_valid),
        .busy      (busy),
        .err_pulse (err_pulse),
        .err_code  (err_code)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // UART transmitter model: busy from the cycle after tx_start for busy_len cycles.
    initial begin
        tx_busy  = 1'b0;
        cur_byte = 8'h00;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                if (tx_count < 64) tx_log[tx_count] = tx_byte;
                tx_count++;
                cur_byte = tx_byte;
                @(posedge clk);
                #1 tx_busy = 1'b1;
                repeat (busy_len) @(posedge clk);
                #1 tx_busy = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (set_valid) sv_count++;
            if (err_pulse) ep_count++;
            if (tx_busy) begin
                checks++;
                if (tx_start !== 1'b0) begin
                    errors++;
                    $display("FAIL tx_start_while_busy: tx_start=%b required 0", tx_start);
                end
                checks++;
                if (tx_byte !== cur_byte) begin
                    errors++;
                    $display("FAIL tx_byte_stable: tx_byte=%h required %h", tx_byte, cur_byte);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    task automatic clear_counts();
        tx_count = 0;
        sv_count = 0;
        ep_count = 0;
        for (int i = 0; i < 64; i++) tx_log[i] = 8'h00;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1 rx_valid = 1'b1;
        rx_byte = b;
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (!busy && !tx_busy) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_idle: busy=%b after %0d cycles, required 0", name, busy, budget);
        end
    endtask

    task automatic check_tx(input string name, input string body);
        logic [7:0] e;
        int n;
        n = body.len() + 2;
        checks++;
        if (tx_count !== n) begin
            errors++;
            $display("FAIL %s_count: tx_start count=%0d required %0d", name, tx_count, n);
        end
        for (int i = 0; i < n; i++) begin
            if (i < body.len()) e = body[i];
            else if (i == body.len()) e = 8'h0D;
            else e = 8'h0A;
            checks++;
            if (tx_log[i] !== e) begin
                errors++;
                $display("FAIL %s_byte%0d: got %h required %h", name, i, tx_log[i], e);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; req_bcd = '0; busy_len = 1;
        clear_counts();
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, set_valid, err_pulse, tx_start, err_code, tx_byte, set_bcd} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b sv=%b ep=%b ts=%b ec=%0d txb=%h set=%h required all 0",
                     busy, set_valid, err_pulse, tx_start, err_code, tx_byte, set_bcd);
        end
        @(negedge clk) rst_n = 1'b1;
        send_str("Z");
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || tx_count !== 0 || ep_count !== 0) begin
            errors++;
            $display("FAIL ignore_byte: busy=%b tx=%0d err=%0d required 0 0 0", busy, tx_count, ep_count);
        end
    endtask

    task automatic test_set();
        clear_counts();
        send_str("K31122024235958");
        @(posedge clk);
        #1;
        checks++;
        if (set_valid !== 1'b1 || set_bcd !== 56'h31122024235958) begin
            errors++;
            $display("FAIL set_commit: set_valid=%b set_bcd=%h required 1 31122024235958", set_valid, set_bcd);
        end
        wait_idle("set", 200);
        checks++;
        if (sv_count !== 1 || ep_count !== 0) begin
            errors++;
            $display("FAIL set_pulses: set_valid=%0d err=%0d required 1 0", sv_count, ep_count);
        end
        check_tx("set_ack", "A");
    endtask

    task automatic test_req();
        clear_counts();
        req_bcd = 56'h01012025000000;
        send_str("R");
        @(negedge clk);
        checks++;
        if (tx_start !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL req_load_cycle: tx_start=%b busy=%b required 0 1", tx_start, busy);
        end
        @(negedge clk);
        checks++;
        if (tx_start !== 1'b1) begin
            errors++;
            $display("FAIL req_latency: tx_start=%b required 1", tx_start);
        end
        req_bcd = 56'h99999999999999;
        wait_idle("req", 400);
        check_tx("req", "01012025000000");
    endtask

    task automatic test_bad_digit();
        clear_counts();
        send_str("K1203X");
        checks++;
        if (err_pulse !== 1'b1 || err_code !== 2'd1) begin
            errors++;
            $display("FAIL bad_digit_err: err_pulse=%b err_code=%0d required 1 1", err_pulse, err_code);
        end
        wait_idle("bad", 200);
        checks++;
        if (ep_count !== 1 || sv_count !== 0 || set_bcd !== 56'h31122024235958) begin
            errors++;
            $display("FAIL bad_digit_state: err=%0d sv=%0d set_bcd=%h required 1 0 31122024235958",
                     ep_count, sv_count, set_bcd);
        end
        check_tx("bad", "E");
    endtask

    task automatic test_timeout();
        int seen;
        clear_counts();
        seen = 0;
        send_str("K1");
        for (int i = 1; i <= 150 && seen == 0; i++) begin
            @(posedge clk);
            #1;
            if (err_pulse) seen = i;
        end
        checks++;
        if (seen !== 100 || err_code !== 2'd2) begin
            errors++;
            $display("FAIL timeout_edge: err at idle cycle %0d code=%0d required 100 2", seen, err_code);
        end
        wait_idle("tmo", 200);
        checks++;
        if (set_bcd !== 56'h31122024235958 || sv_count !== 0) begin
            errors++;
            $display("FAIL timeout_set_bcd: set_bcd=%h sv=%0d required 31122024235958 0", set_bcd, sv_count);
        end
        check_tx("tmo", "E");
    endtask

    task automatic test_timeout_race();
        clear_counts();
        send_str("K1");
        repeat (98) @(posedge clk);
        send_str("2");
        send_str("345678901234");
        wait_idle("race", 200);
        checks++;
        if (ep_count !== 0 || sv_count !== 1 || set_bcd !== 56'h12345678901234) begin
            errors++;
            $display("FAIL timeout_race: err=%0d sv=%0d set_bcd=%h required 0 1 12345678901234",
                     ep_count, sv_count, set_bcd);
        end
        check_tx("race", "A");
    endtask

    task automatic test_busy_stress();
        busy_len = 50;
        clear_counts();
        req_bcd = 56'h98765432109876;
        send_str("R");
        repeat (300) @(posedge clk);
        send_str("RK");
        wait_idle("stress", 3000);
        check_tx("stress", "98765432109876");
        repeat (30) @(negedge clk);
        checks++;
        if (tx_count !== 16 || busy !== 1'b0 || ep_count !== 0) begin
            errors++;
            $display("FAIL stress_drop: tx=%0d busy=%b err=%0d required 16 0 0", tx_count, busy, ep_count);
        end
        busy_len = 1;
    endtask

    task automatic test_reset_mid();
        clear_counts();
        send_str("K123456");
        @(posedge clk);
        #1 rx_valid = 1'b1;
        rx_byte = 8'h37;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, set_valid, err_pulse, tx_start, err_code, tx_byte, set_bcd} !== '0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b ec=%0d txb=%h set=%h required all 0",
                     busy, err_code, tx_byte, set_bcd);
        end
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_counts();
        send_str("K20250101123000");
        @(posedge clk);
        #1;
        checks++;
        if (set_valid !== 1'b1 || set_bcd !== 56'h20250101123000) begin
            errors++;
            $display("FAIL reset_recover: set_valid=%b set_bcd=%h required 1 20250101123000", set_valid, set_bcd);
        end
        wait_idle("rst", 200);
        check_tx("rst_ack", "A");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_set();
        test_req();
        test_bad_digit();
        test_timeout();
        test_timeout_race();
        test_busy_stress();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
